// File: rtl/carry_lookahead_pkg.sv
// rtl/carry_lookahead_pkg.sv - shared width constant and types for the 4-bit carry-lookahead adder
package carry_lookahead_pkg;

  localparam int CLA_WIDTH = 4;

  typedef logic [CLA_WIDTH-1:0] nibble_t;

  // Carry-out in the MSB, sum in the low nibble.
  typedef logic [CLA_WIDTH:0] cla_result_t;

endpackage

// File: rtl/cla_pg_cell.sv
// rtl/cla_pg_cell.sv - one-bit generate/propagate cell with sum output
module cla_pg_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic g,
  output logic p,
  output logic s
);

  // Generate and propagate come from the operand bits only; the sum also needs this bit's carry.
  always_comb begin
    g = a & b;
    p = a ^ b;
    s = p ^ c;
  end

endmodule

// File: rtl/carry_lookahead_adder.sv
// rtl/carry_lookahead_adder.sv - registered 4-bit carry-lookahead adder; CARRY_LOOKAHEAD_IN_REG_EN adds operand entry registers
module carry_lookahead_adder
  import carry_lookahead_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic C0,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic Cout_4
);

  nibble_t     a_in;
  nibble_t     b_in;
  nibble_t     a_op;
  nibble_t     b_op;
  logic        c0_op;
  nibble_t     g;
  nibble_t     p;
  nibble_t     s;
  nibble_t     c_in;
  logic [CLA_WIDTH:1] c_sop;
  cla_result_t result_d;
  cla_result_t result_q;

  // Gather the individual operand pins into vectors, bit 3 is the MSB.
  always_comb begin
    a_in = {A3, A2, A1, A0};
    b_in = {B3, B2, B1, B0};
  end

`ifdef CARRY_LOOKAHEAD_IN_REG_EN
  // Capture operands on entry so the lookahead logic starts from flops; adds one cycle of latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_op  <= '0;
      b_op  <= '0;
      c0_op <= 1'b0;
    end else begin
      a_op  <= a_in;
      b_op  <= b_in;
      c0_op <= C0;
    end
  end
`else
  // Operand pins feed the lookahead logic directly.
  always_comb begin
    a_op  = a_in;
    b_op  = b_in;
    c0_op = C0;
  end
`endif

  // Each bit's carry-in comes from the parallel carry network, bit 0 from C0.
  always_comb begin
    c_in = {c_sop[CLA_WIDTH-1:1], c0_op};
  end

  for (genvar i = 0; i < CLA_WIDTH; i++) begin : g_pg
    cla_pg_cell u_pg (
      .a (a_op[i]),
      .b (b_op[i]),
      .c (c_in[i]),
      .g (g[i]),
      .p (p[i]),
      .s (s[i])
    );
  end

  // Carries as flat sum-of-products of G, P and C0 so no carry depends on another carry.
  always_comb begin
    c_sop    = '0;
    c_sop[1] = g[0]
             | (p[0] & c0_op);
    c_sop[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c0_op);
    c_sop[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0_op);
    c_sop[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0_op);
  end

  // Assemble carry-out and sum into one result word.
  always_comb begin
    result_d = {c_sop[CLA_WIDTH], s};
  end

  // Register the result; reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  // Drive the individual output pins from the result register.
  always_comb begin
    S3     = result_q[3];
    S2     = result_q[2];
    S1     = result_q[1];
    S0     = result_q[0];
    Cout_4 = result_q[CLA_WIDTH];
  end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// tb/tb_carry_lookahead_adder.sv - self-checking bench for carry_lookahead_adder, both latency builds
module tb_carry_lookahead_adder;

`ifdef CARRY_LOOKAHEAD_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c0;
  logic       s3, s2, s1, s0, cout;
  logic [4:0] dut_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] exp_out;
  logic [4:0] stage;
  logic       model_ok = 1'b0;

  always #5 clk = ~clk;

  carry_lookahead_adder dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A3     (a[3]),
    .A2     (a[2]),
    .A1     (a[1]),
    .A0     (a[0]),
    .B3     (b[3]),
    .B2     (b[2]),
    .B1     (b[1]),
    .B0     (b[0]),
    .C0     (c0),
    .S3     (s3),
    .S2     (s2),
    .S1     (s1),
    .S0     (s0),
    .Cout_4 (cout)
  );

  assign dut_out = {cout, s3, s2, s1, s0};

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output after an edge is A+B+C0 as seen LAT edges earlier,
  // zero if reset was low at any edge in that window.
  always @(posedge clk) begin
    logic [4:0] now_val;
    now_val = rst_n ? (5'(a) + 5'(b) + 5'(c0)) : 5'd0;
    if (LAT == 2) begin
      exp_out = rst_n ? stage : 5'd0;
      stage   = now_val;
    end else begin
      exp_out = now_val;
    end
    if (!rst_n) model_ok = 1'b1;
  end

  // Compare DUT against the model on every falling edge once reset has defined the state.
  always @(negedge clk) begin
    if (model_ok) check("stream", dut_out, exp_out);
  end

  task automatic drive(input logic r, input logic [3:0] av, input logic [3:0] bv, input logic cv);
    @(posedge clk);
    #1;
    rst_n = r;
    a     = av;
    b     = bv;
    c0    = cv;
  endtask

  task automatic directed(input string name, input logic [3:0] av, input logic [3:0] bv,
                          input logic cv, input logic [4:0] lit);
    drive(1'b1, av, bv, cv);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    check(name, dut_out, lit);
    check({name, "_model"}, exp_out, lit);
  endtask

  initial begin
    rst_n = 1'b1;
    a     = '0;
    b     = '0;
    c0    = 1'b0;
    stage = '0;

    // Reset with all-ones operands must still clear the outputs after one edge.
    drive(1'b0, 4'hf, 4'hf, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("reset", dut_out, 5'b00000);
    check("reset_model", exp_out, 5'b00000);
    drive(1'b0, 4'hf, 4'hf, 1'b1);

    directed("3+5", 4'd3, 4'd5, 1'b0, 5'b01000);

    // Back-to-back operands produce results on consecutive cycles.
    drive(1'b1, 4'd7, 4'd7, 1'b0);
    drive(1'b1, 4'd9, 4'd6, 1'b0);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("7+7", dut_out, 5'b01110);
    @(negedge clk);
    check("9+6", dut_out, 5'b01111);

    directed("10+10", 4'd10, 4'd10, 1'b0, 5'b10100);
    directed("15+0+1", 4'd15, 4'd0, 1'b1, 5'b10000);
    directed("15+15+1", 4'd15, 4'd15, 1'b1, 5'b11111);
    directed("0+0+0", 4'd0, 4'd0, 1'b0, 5'b00000);

    // Exhaustive sweep with a reset pulse in the middle.
    for (int i = 0; i < 512; i++) begin
      drive((i == 256) ? 1'b0 : 1'b1, 4'(i >> 5), 4'(i >> 1), i[0]);
      if (i == 257) begin
        @(negedge clk);
        check("flush", dut_out, 5'b00000);
      end
    end

    // Random operands with occasional resets.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1,
            4'($urandom), 4'($urandom), 1'($urandom));
    end

    drive(1'b1, 4'd0, 4'd0, 1'b0);
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
